nibble_serial_add_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit additions by reusing one external 4-bit ripple-carry adder slice, one nibble per clock, least significant nibble first. It accepts operands over a valid/ready handshake and drives the slice's operand and carry-in pins. It registers each nibble's sum and the inter-nibble carry, and returns the full result over a second valid/ready handshake. It sits between a requesting datapath and the shared 4-bit adder slice.

---
 rtl/nibble_serial_add_ctrl.sv | 132 +++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit adder sequencer driving a shared 4-bit ripple-carry slice, LS nibble first.
// Optional `OVERFLOW_FLAG_EN adds out_ovf (signed overflow of the final nibble).
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
`ifdef OVERFLOW_FLAG_EN
    output logic             out_ovf,
`endif
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic [3:0]       add_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    logic [1:0]       state_r;
    logic [IW-1:0]    idx_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             out_valid_r;
    logic             out_cout_r;
    logic             ovf_r;
    logic [IW+1:0]    bit_off_s;

    // Bit offset of the current nibble inside the operand/sum registers.
    assign bit_off_s = {idx_r, 2'b00};

    assign in_ready  = (state_r == IDLE) & ~rst;
    assign out_valid = out_valid_r;
    assign out_sum   = sum_r;
    assign out_cout  = out_cout_r;
`ifdef OVERFLOW_FLAG_EN
    assign out_ovf   = ovf_r;
`endif

    // Slice operand pins: live only in RUN, quiet otherwise.
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        case (state_r)
            RUN: begin
                add_a   = a_r[bit_off_s +: 4];
                add_b   = b_r[bit_off_s +: 4];
                add_cin = carry_r;
            end
            default: begin
                add_a   = 4'h0;
                add_b   = 4'h0;
                add_cin = 1'b0;
            end
        endcase
    end

    // Sequencer state, operand capture and per-nibble result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            carry_r     <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            out_valid_r <= 1'b0;
            out_cout_r  <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        b_r     <= in_b;
                        carry_r <= in_cin;
                        idx_r   <= '0;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    sum_r[bit_off_s +: 4] <= add_sum;
                    carry_r               <= add_cout[3];
                    if (idx_r == LAST_IDX) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        out_cout_r  <= add_cout[3];
                        ovf_r       <= add_cout[3] ^ add_cout[2];
                        idx_r       <= '0;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifndef OVERFLOW_FLAG_EN
    logic unused_ovf_s;
    assign unused_ovf_s = ovf_r;
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl with a behavioural 4-bit ripple slice.
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic [3:0]  add_cout;
`ifdef OVERFLOW_FLAG_EN
    logic        out_ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [17:0] exp_q[$];   // {ovf, cout, sum}
    int          stamp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
`ifdef OVERFLOW_FLAG_EN
        .out_ovf(out_ovf),
`endif
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    // External 4-bit ripple-carry slice.
    always_comb begin
        logic c;
        c = add_cin;
        add_sum  = 4'h0;
        add_cout = 4'h0;
        for (int i = 0; i < 4; i++) begin
            add_sum[i]  = add_a[i] ^ add_b[i] ^ c;
            c           = (add_a[i] & add_b[i]) | (add_a[i] & c) | (add_b[i] & c);
            add_cout[i] = c;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation for every accepted result.
    always @(negedge clk) begin
        logic [17:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got sum %h with no expectation", out_sum);
            end else begin
                e = exp_q.pop_front();
                check("result_sum", 32'(out_sum), 32'(e[15:0]));
                check("result_cout", 32'(out_cout), 32'(e[16]));
`ifdef OVERFLOW_FLAG_EN
                check("result_ovf", 32'(out_ovf), 32'(e[17]));
`endif
                stamp_q.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation, wait (bounded) for acceptance; returns just after the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] es, input logic ec, input logic eo, input bit push);
        int k;
        if (push) exp_q.push_back({eo, ec, es});
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        #1;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (k == 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        if (k == 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst = 1'b1; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; in_cin = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_add_a", 32'({add_a, add_b, add_cin}), 32'd0);

        // 1: latency and single-cycle valid
        issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("latency_valid", 32'(out_valid), (i == 4) ? 32'd1 : 32'd0);
        end
        tick();
        check("valid_one_cycle", 32'(out_valid), 32'd0);
        drain();

        // 2: carry ripples across nibbles
        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        check("run_add_a0", 32'(add_a), 32'hF);
        check("run_add_b0", 32'(add_b), 32'h1);
        check("run_cin0", 32'(add_cin), 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("run_cin", 32'(add_cin), 32'd1);
        end
        drain();

        // 3: backpressure with a pending request
        out_ready = 1'b0;
        issue(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        exp_q.push_back({1'b1, 1'b1, 16'h0000});
        in_a = 16'h8000; in_b = 16'h8000; in_cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_sum_hold", 32'(out_sum), 32'h1000);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        tick();
        check("bp_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        drain();

        // 4: reset mid-operation
        issue(16'hAAAA, 16'h5555, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_sum", 32'(out_sum), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
        drain();

        // 5: carry-in only, then back-to-back throughput
        stamp_q.delete();
        issue(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
        issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
        issue(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b1);
        issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        drain();
        check("b2b_count", 32'(stamp_q.size()), 32'd4);
        if (stamp_q.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("b2b_spacing", 32'(stamp_q[i] - stamp_q[i-1]), 32'd6);
        end

        // 6: overflow flag vectors (flag checked only when present)
        issue(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
